// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state type, frame constants and parity helper for the PS/2 host path
package ps2_pkg;

   // Host transmit sequencer states, in the order a frame walks through them.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      RELEASE   = 3'd2,
      SEND      = 3'd3,
      ACK       = 3'd4,
      WAIT_IDLE = 3'd5
   } state_e;

   // Bits shifted out after the start bit: eight data bits plus parity.
   localparam int FRAME_BITS = 9;

   // Common keyboard commands and the keyboard's acknowledge byte.
   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] ACK_BYTE    = 8'hFA;

   // Odd parity: the returned bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - PS/2 clock/data pin synchronizers with device-clock falling-edge pulse
module ps2_line_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic clk_o,
   output logic data_o,
   output logic fall_o
);

   // Stage [0] is the metastability catcher; the lines idle high, so reset to 1
   // to avoid a false falling edge right after reset.
   logic [2:0] clk_sync_q;
   logic [2:0] data_sync_q;

   // Shift both raw pins through three flops each.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         clk_sync_q  <= 3'b111;
         data_sync_q <= 3'b111;
      end else begin
         clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
         data_sync_q <= {data_sync_q[1:0], ps2_data_i};
      end
   end

   // The clock level is taken one stage early so the last stage can serve as
   // the "previous" sample for edge detection; data uses the full chain.
   assign clk_o  = clk_sync_q[1];
   assign fall_o = clk_sync_q[2] & ~clk_sync_q[1];
   assign data_o = data_sync_q[2];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   // INHIBIT lasts INHIBIT_CYCLES-1 cycles; the RELEASE cycle supplies the last
   // cycle of clock hold-low, so the clock is pulled for INHIBIT_CYCLES in total.
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 2);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS);

   state_e                state_q, state_d;
   logic [INH_W-1:0]      inh_cnt_q, inh_cnt_d;
   logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic                  clk_oe_q, clk_oe_d;
   logic                  data_oe_q, data_oe_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic sync_clk;
   logic sync_data;
   logic fall;
   logic accept;
   logic timeout_hit;

   ps2_line_sync u_sync (
      .clk_i      (clk),
      .rst_i      (rst),
      .ps2_clk_i  (ps2_clk),
      .ps2_data_i (ps2_data),
      .clk_o      (sync_clk),
      .data_o     (sync_data),
      .fall_o     (fall)
   );

   // The completion pulse cycle is already IDLE but still masks tx_ready, so a
   // new request is only taken the cycle after done/err.
   assign tx_ready    = (state_q == IDLE) && !done_q && !err_q;
   assign accept      = tx_valid && tx_ready;
   assign busy        = (state_q != IDLE);
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign done        = done_q;
   assign err         = err_q;

   // State and datapath registers; reset releases both lines immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         inh_cnt_q <= '0;
         to_cnt_q  <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         inh_cnt_q <= inh_cnt_d;
         to_cnt_q  <= to_cnt_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Next-state and next-output logic; line enables only move on transitions.
   always_comb begin
      state_d     = state_q;
      inh_cnt_d   = inh_cnt_q;
      to_cnt_d    = to_cnt_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      clk_oe_d    = clk_oe_q;
      data_oe_d   = data_oe_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      timeout_hit = 1'b0;

      // Watchdog on the device clock while the device is expected to clock.
      if (state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) begin
         to_cnt_d    = fall ? '0 : to_cnt_q + TO_W'(1);
         timeout_hit = !fall && (to_cnt_q == TO_LAST);
      end

      case (state_q)
         IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (accept) begin
               shift_d   = {odd_parity(tx_data), tx_data};
               bit_cnt_d = '0;
               inh_cnt_d = '0;
               clk_oe_d  = 1'b1;
               state_d   = INHIBIT;
            end
         end

         INHIBIT: begin
            if (inh_cnt_q == INH_LAST) begin
               data_oe_d = 1'b1;
               state_d   = RELEASE;
            end else begin
               inh_cnt_d = inh_cnt_q + INH_W'(1);
            end
         end

         RELEASE: begin
            clk_oe_d = 1'b0;
            to_cnt_d = '0;
            state_d  = SEND;
         end

         SEND: begin
            if (fall) begin
               if (bit_cnt_q < LAST_BIT) begin
                  data_oe_d = ~shift_q[0];
                  shift_d   = shift_q >> 1;
               end else begin
                  data_oe_d = 1'b0;
                  state_d   = ACK;
               end
               if (bit_cnt_q != 4'hF) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end

         ACK: begin
            if (fall) begin
               if (sync_data) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT_IDLE;
               end
            end
         end

         WAIT_IDLE: begin
            if (sync_clk && sync_data) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = IDLE;
         end
      endcase

      if (timeout_hit) begin
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
         done_d    = 1'b0;
         err_d     = 1'b1;
         state_d   = IDLE;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a behavioural PS/2 device
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH = 200;
   localparam int TO  = 2000;
   localparam int H   = 20;

   typedef struct packed {
      logic [7:0]  data;
      logic [1:0]  mode;       // 0 normal ack, 1 no ack, 2 device stalls after fall 4
      logic [10:0] exp_frame;  // bit k = line level sampled at device rise k (bit 0 = start)
      logic        exp_done;
      logic        exp_err;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       clk_line, data_line;

   assign clk_line  = !(ps2_clk_oe || dev_clk_low);
   assign data_line = !(ps2_data_oe || dev_data_low);

   int n_pass = 0;
   int n_total = 0;
   int neg_cyc = 0, acc_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
   int rdy_busy_cnt = 0, oe_run = 0, oe_last_run = 0;
   logic [3:0] pulse_snap = 4'h0;
   logic [3:0] post_snap  = 4'h0;
   logic       pulse_prev = 1'b0;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .ps2_clk     (clk_line),
      .ps2_data    (data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      neg_cyc <= neg_cyc + 1;
      if (tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      if (done && err) both_cnt <= both_cnt + 1;
      if (tx_ready && busy) rdy_busy_cnt <= rdy_busy_cnt + 1;
      if (ps2_clk_oe) oe_run <= oe_run + 1;
      else begin
         if (oe_run != 0) oe_last_run <= oe_run;
         oe_run <= 0;
      end
      if (done || err) pulse_snap <= {tx_ready, busy, ps2_clk_oe, ps2_data_oe};
      if (pulse_prev) post_snap <= {tx_ready, busy, ps2_clk_oe, ps2_data_oe};
      pulse_prev <= done || err;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: start 0, data LSB first, odd parity over the data, stop 1.
   function automatic logic [10:0] model_frame(input logic [7:0] d);
      logic [10:0] f;
      int ones;
      ones = 0;
      f = '0;
      for (int i = 0; i < 8; i++) begin
         f[i + 1] = d[i];
         if (d[i]) ones++;
      end
      f[9]  = ((ones % 2) == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic run_frame(input logic [7:0] d, input int mode, input logic hold,
                            input logic [7:0] hold_d, input logic pre_acc,
                            output logic [10:0] cap, output int dly,
                            output int n_done, output int n_err);
      int n;
      int base_done, base_err, base_acc, t_fall;
      cap = '0;
      dly = -1;
      t_fall = 0;
      if (!pre_acc) begin
         tx_data = d;
         tx_valid = 1'b1;
         n = 0;
         while (!tx_ready && n < 100) begin @(negedge clk); n++; end
         check("accept_wait", 32'(n < 100), 32'd1);
         @(posedge clk);
         @(negedge clk);
      end
      check("busy_after_accept", 32'(busy), 32'd1);
      base_done = done_cnt;
      base_err  = err_cnt;
      base_acc  = acc_cnt;
      if (hold) tx_data = hold_d;
      else begin
         tx_valid = 1'b0;
         tx_data = 8'($urandom);
      end
      n = 0;
      while (!(clk_line && !data_line) && n < INH + 50) begin @(negedge clk); n++; end
      check("rts_wait", 32'(n < INH + 50), 32'd1);
      repeat (H) @(negedge clk);
      check("inhibit_len", 32'(oe_last_run), 32'(INH));
      cap[0] = data_line;
      for (int k = 1; k <= 10; k++) begin
         dev_clk_low = 1'b1;
         if (k == 4) t_fall = neg_cyc;
         repeat (H) @(negedge clk);
         dev_clk_low = 1'b0;
         cap[k] = data_line;
         if (mode == 2 && k == 4) break;
         repeat (H) @(negedge clk);
      end
      if (mode == 2) begin
         n = 0;
         while (!err && n < TO + 100) begin @(negedge clk); n++; end
         dly = neg_cyc - t_fall;
      end else begin
         repeat (H / 2) @(negedge clk);
         if (mode == 0) dev_data_low = 1'b1;
         repeat (H / 2) @(negedge clk);
         dev_clk_low = 1'b1;
         repeat (H) @(negedge clk);
         dev_clk_low = 1'b0;
         repeat (H / 2) @(negedge clk);
         dev_data_low = 1'b0;
      end
      n = 0;
      while ((done_cnt + err_cnt) == (base_done + base_err) && n < TO + 200) begin
         @(negedge clk);
         n++;
      end
      check("pulse_wait", 32'(n < TO + 200), 32'd1);
      check("no_accept_while_busy", 32'(acc_cnt - base_acc), 32'd0);
      @(negedge clk);
      check("pulse_cycle_state", 32'(pulse_snap), 32'h0);
      check("after_pulse_state", 32'(post_snap), 32'h8);
      n_done = done_cnt - base_done;
      n_err  = err_cnt - base_err;
   endtask

   vec_t        vecs [7];
   logic [10:0] cap;
   int          dly, nd, ne, n;
   logic [7:0]  rd;
   int          rmode;
   int          base_done, base_err;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{CMD_SET_LED, 2'd0, 11'h7DA, 1'b1, 1'b0};
      vecs[1] = '{8'h01,       2'd0, 11'h402, 1'b1, 1'b0};
      vecs[2] = '{8'h00,       2'd0, 11'h600, 1'b1, 1'b0};
      vecs[3] = '{CMD_RESET,   2'd0, 11'h7FE, 1'b1, 1'b0};
      vecs[4] = '{ACK_BYTE,    2'd0, 11'h7F4, 1'b1, 1'b0};
      vecs[5] = '{8'hA5,       2'd1, 11'h74A, 1'b0, 1'b1};
      vecs[6] = '{8'hF4,       2'd0, 11'h5E8, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Table of directed frames.
      for (int i = 0; i < 7; i++) begin
         run_frame(vecs[i].data, int'(vecs[i].mode), 1'b0, 8'h00, 1'b0, cap, dly, nd, ne);
         check($sformatf("frame_%02h", vecs[i].data), 32'(cap), 32'(vecs[i].exp_frame));
         check($sformatf("done_%02h", vecs[i].data), 32'(nd), 32'(vecs[i].exp_done));
         check($sformatf("err_%02h", vecs[i].data), 32'(ne), 32'(vecs[i].exp_err));
      end

      // Device stalls after fall 4: watchdog abort.
      run_frame(8'h3C, 2, 1'b0, 8'h00, 1'b0, cap, dly, nd, ne);
      check("stall_err", 32'(ne), 32'd1);
      check("stall_done", 32'(nd), 32'd0);
      check("stall_delay_window", 32'(dly >= TO && dly <= TO + 6), 32'd1);

      // tx_valid held with 0xFF across a frame: taken only after completion.
      run_frame(8'h5A, 0, 1'b1, CMD_RESET, 1'b0, cap, dly, nd, ne);
      check("hold_first_frame", 32'(cap), 32'(model_frame(8'h5A)));
      check("hold_first_done", 32'(nd), 32'd1);
      run_frame(CMD_RESET, 0, 1'b0, 8'h00, 1'b1, cap, dly, nd, ne);
      check("hold_second_frame", 32'(cap), 32'h7FE);
      check("hold_second_done", 32'(nd), 32'd1);

      // Reset in the middle of SEND.
      tx_data = 8'h00;
      tx_valid = 1'b1;
      n = 0;
      while (!tx_ready && n < 100) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
      n = 0;
      while (!(clk_line && !data_line) && n < INH + 50) begin @(negedge clk); n++; end
      check("rstmid_rts_wait", 32'(n < INH + 50), 32'd1);
      repeat (H) @(negedge clk);
      for (int k = 1; k <= 3; k++) begin
         dev_clk_low = 1'b1;
         repeat (H) @(negedge clk);
         dev_clk_low = 1'b0;
         repeat (H) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (5) @(negedge clk);
      check("rstmid_data_oe_before", 32'(ps2_data_oe), 32'd1);
      base_done = done_cnt;
      base_err  = err_cnt;
      #2 rst = 1'b1;
      #1;
      check("rstmid_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("rstmid_data_oe", 32'(ps2_data_oe), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      dev_clk_low = 1'b0;
      check("rstmid_no_pulse", 32'((done_cnt - base_done) + (err_cnt - base_err)), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      run_frame(8'hF4, 0, 1'b0, 8'h00, 1'b0, cap, dly, nd, ne);
      check("after_rst_frame", 32'(cap), 32'h5E8);
      check("after_rst_done", 32'(nd), 32'd1);

      // Randomized frames against the reference model.
      for (int r = 0; r < 6; r++) begin
         rd = 8'($urandom);
         rmode = int'($urandom_range(0, 1));
         run_frame(rd, rmode, 1'b0, 8'h00, 1'b0, cap, dly, nd, ne);
         check($sformatf("rand_frame_%02h", rd), 32'(cap), 32'(model_frame(rd)));
         check($sformatf("rand_done_%02h", rd), 32'(nd), 32'(rmode == 0));
         check($sformatf("rand_err_%02h", rd), 32'(ne), 32'(rmode == 1));
      end

      check("done_err_exclusive", 32'(both_cnt), 32'd0);
      check("ready_only_idle", 32'(rdy_busy_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the attached keyboard. It is the opposite direction of the existing keyboard receive path.
- Drives the open-drain PS/2 clock and data lines through active-high pull-low enables.
- Top level builds the tri-state pads from these enables.
- `busy` masks the keyboard receiver while a frame is outgoing.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before start (100 us at 50 MHz)
TIMEOUT_CYCLES, 1000000, max clk cycles without a device clock edge before abort (20 ms at 50 MHz)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
tx_data  in  8  byte to send, captured on accept
tx_valid  in  1  request to send tx_data
tx_ready  out  1  high only in IDLE; accept = tx_valid & tx_ready
ps2_clk  in  1  raw PS/2 clock pin level (asynchronous)
ps2_data  in  1  raw PS/2 data pin level (asynchronous)
ps2_clk_oe  out  1  1 = pull clock line low, 0 = release
ps2_data_oe  out  1  1 = pull data line low, 0 = release
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse: device acknowledged the frame
err  out  1  1-cycle pulse: timeout or missing ack

Behaviour:
Reset (asynchronous):
- State = IDLE; tx_ready=1; both oe=0; busy=0; done=0; err=0.
- Counters and shift register are cleared.
- Reset mid-frame releases both lines at once; no done or err pulse.

Synchronizer and edge detect:
- Each of ps2_clk and ps2_data passes through a 3-flop synchronizer.
- Falling edge (fall) = previous synced clock 1 and current synced clock 0.
- fall is seen 3 clk cycles after the pin transition.

Accept:
- On tx_valid & tx_ready, latch tx_data.
- Compute parity = ~^tx_data (odd parity).
- Load the 9-bit frame {parity, data[7:0]}, sent LSB first. Go to INHIBIT.

States:
- IDLE: both oe=0. On accept, go to INHIBIT.
- INHIBIT: ps2_clk_oe=1. Count INHIBIT_CYCLES. Then ps2_data_oe=1 (start bit 0) and go to RELEASE.
- RELEASE: one cycle with ps2_clk_oe=1 and ps2_data_oe=1. Then ps2_clk_oe=0 and go to SEND. The timeout counter is cleared here.
- SEND: on each fall, drive the next frame bit as ps2_data_oe = ~bit.
  - fall 1..8 → data bits 0..7; fall 9 → parity.
  - On fall 10, ps2_data_oe=0 (stop bit released) and go to ACK.
  - The bit counter is 4 bits wide and saturates; no wrap.
- ACK: on the next fall, sample synced data.
  - 0 → go to WAIT_IDLE.
  - 1 → err pulse, go to IDLE.
- WAIT_IDLE: wait until synced clock and data are both 1. Then done pulse, go to IDLE.

Timeout:
- Applies in SEND, ACK and WAIT_IDLE.
- A counter increments each clk and is cleared on every fall.
- Reaching TIMEOUT_CYCLES → both oe=0, err pulse, go to IDLE.

Rules:
- done and err are mutually exclusive, 1 cycle each, asserted in the cycle the state returns to IDLE.
- tx_ready rises the following cycle.
- tx_valid is ignored while busy; no queuing.
- tx_data changes after accept have no effect.
- Device-clock edges in IDLE or INHIBIT are ignored; the host owns the line while inhibiting.
- oe outputs are registered; they never glitch or toggle on any clk cycle other than the state transitions above.

Decomposition:
- Package ps2_pkg:
  - state enum {IDLE, INHIBIT, RELEASE, SEND, ACK, WAIT_IDLE}
  - FRAME_BITS=9
  - odd-parity function
  - command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, ACK_BYTE=8'hFA
- Sub-module ps2_line_sync: 3-flop synchronizers plus the falling-edge pulse. It is reusable by the keyboard receiver.

Test Plan:
1. Reset, then send 0xED; the device model clocks at 12 kHz and pulls ack low → ps2_clk_oe high for exactly 5000 cycles. Data seen on device rising edges: 0,1,0,1,1,0,1,1,1,1(parity),1(stop). Then done pulses once and tx_ready returns to 1.
2. Send 0x01 and 0x00 → parity bits 0 and 1 respectively; the frame for 0x00 is 0, eight 0s, 1, 1.
3. Device omits ack (data stays high on fall 11) → err pulses once, done stays 0, both oe are 0, state is IDLE.
4. Device stops clocking after fall 4 (TIMEOUT_CYCLES=2000 in the bench) → err 2000 cycles after the last fall, lines released.
5. Hold tx_valid with 0xFF during a frame → no second accept until done. Then 0xFF is sent with parity 1.
6. Assert rst mid-SEND → ps2_clk_oe and ps2_data_oe go to 0 the same cycle, busy=0, no pulses. After reset release, a new 0xF4 frame completes normally.
